mux41_scan_ctrl: RTL and testbench
==================================

MUX41_SCAN_CTRL -- requirements
Module: mux41_scan_ctrl

Upstream sequencer for the 4:1 mux stage. It drives data word i and selects j0/j1, dwells on each channel, captures the mux output o back through y, and assembles a 4-bit result word.

Interface
REQ-001 SHALL have: clk  input  1  single clock, all state changes on rising edge.
REQ-002 SHALL have: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: start  input  1  request a scan; sampled only in IDLE.
REQ-004 SHALL have: stop  input  1  abort the scan; sampled in every state.
REQ-005 SHALL have: mode  input  1  0 = single sweep, 1 = continuous sweeps.
REQ-006 SHALL have: dwell  input  4  cycles per channel minus one (hold = dwell+1 cycles).
REQ-007 SHALL have: data_in  input  [0:3]  pattern latched into i at start.
REQ-008 SHALL have: y  input  1  mux output o, fed back.
REQ-009 SHALL have: i  output  [0:3]  registered data word to the mux i port.
REQ-010 SHALL have: j0  output  1  select MSB; j1  output  1  select LSB; channel index = {j0,j1}, index 0 selects i[0].
REQ-011 SHALL have: busy  output  1  high in LOAD and SCAN.
REQ-012 SHALL have: result  output  [0:3]  captured y per channel; result_valid  output  1  one-cycle pulse per completed sweep.
REQ-013 SHALL have: done  output  1  one-cycle pulse at the end of a single sweep.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SCAN, DONE; all outputs registered.
REQ-015 IDLE: busy=0, {j0,j1}=00, i holds its last value; start=1 and stop=0 -> LOAD, latching data_in->i and dwell->dwell_r.
REQ-016 LOAD: one cycle; ch=0, cnt=0, busy=1 -> SCAN.
REQ-017 SCAN: {j0,j1}=ch; cnt increments by 1 each cycle; cnt is a 4-bit counter and never wraps before reaching dwell_r.
REQ-018 SCAN, cnt==dwell_r: sample y into capture bit ch; cnt<=0; when ch<3, ch<=ch+1.
REQ-019 SCAN, cnt==dwell_r and ch==3: copy the complete capture word (bit 3 = this cycle's y) into result and pulse result_valid next cycle.
REQ-020 REQ-019 with mode=0 -> DONE; with mode=1 -> ch wraps to 0 and the FSM stays in SCAN.
REQ-021 SHALL sample mode at every ch==3 boundary, so a mid-scan change takes effect at the end of the current sweep.
REQ-022 DONE: done=1 for one cycle, busy=0 -> IDLE.
REQ-023 stop=1 in LOAD/SCAN/DONE -> IDLE next cycle; result is unchanged, and no result_valid or done pulse is generated.
REQ-024 start while busy SHALL be ignored; start and stop together in IDLE SHALL leave the FSM in IDLE.
REQ-025 dwell=0 SHALL give one cycle per channel; a single sweep is 1 (LOAD) + 4*(dwell+1) (SCAN) + 1 (DONE) cycles from the start edge.
REQ-026 y sampled at the final dwell cycle SHALL be the mux output for the current {j0,j1} and i (combinational mux, settled).

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, i=0000, j0=j1=0, busy=0, result=0000, result_valid=0, done=0, cnt=0, ch=0.
REQ-028 Reset asserted mid-scan SHALL abort without a done or result_valid pulse; the first rising edge after rst_n=1 SHALL evaluate IDLE.

Verification
REQ-029 Reset then idle: rst_n low 2 cycles -> all outputs zero, state IDLE, start ignored while rst_n=0.
REQ-030 Single sweep: data_in=1010, dwell=0, mode=0, start pulse -> {j0,j1} 00,01,10,11 one cycle each, result=1010 with result_valid, done 6 cycles after start edge, busy then 0.
REQ-031 Dwell: data_in=0001, dwell=3 -> each select held 4 cycles, result=0001, done at cycle 18.
REQ-032 Continuous: mode=1, data_in=0110, dwell=1 -> result_valid every 8 cycles with result=0110; clear mode mid-sweep -> done after that sweep.
REQ-033 Abort: stop during ch=2 -> IDLE next cycle, result keeps prior value, no done; start during SCAN has no effect.
REQ-034 Async reset mid-scan (ch=1): rst_n low between edges -> outputs zero before the next edge; restart -> normal sweep.

Source files
------------

// File: rtl/mux41_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: drives i and {j0,j1}, holds each channel for dwell+1
// cycles, captures y per channel into result. Latency: 1 (LOAD) + 4*(dwell+1) + 1 (DONE) cycles.
module mux41_scan_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [3:0] dwell,
  input  logic [0:3] data_in,
  input  logic       y,
  output logic [0:3] i,
  output logic       j0,
  output logic       j1,
  output logic       busy,
  output logic [0:3] result,
  output logic       result_valid,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t     state_q, state_d;
  logic [0:3] i_q, i_d;
  logic [3:0] dwell_q, dwell_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ch_q, ch_d;
  logic [0:3] cap_q, cap_d;
  logic [1:0] j_q, j_d;
  logic       busy_q, busy_d;
  logic [0:3] result_q, result_d;
  logic       result_valid_q, result_valid_d;
  logic       done_q, done_d;

  always_comb begin
    state_d        = state_q;
    i_d            = i_q;
    dwell_d        = dwell_q;
    cnt_d          = cnt_q;
    ch_d           = ch_q;
    cap_d          = cap_q;
    j_d            = j_q;
    busy_d         = busy_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        j_d    = 2'd0;
        busy_d = 1'b0;
        if (start && !stop) begin
          state_d = LOAD;
          i_d     = data_in;
          dwell_d = dwell;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          j_d     = 2'd0;
        end else begin
          state_d = SCAN;
          ch_d    = 2'd0;
          cnt_d   = 4'd0;
          cap_d   = 4'b0000;
          j_d     = 2'd0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (stop) begin
          // Abort wins over a coinciding capture: result stays untouched.
          state_d = IDLE;
          busy_d  = 1'b0;
          j_d     = 2'd0;
          cnt_d   = 4'd0;
          ch_d    = 2'd0;
        end else if (cnt_q == dwell_q) begin
          cap_d[ch_q] = y;
          cnt_d       = 4'd0;
          if (ch_q == 2'd3) begin
            result_d       = {cap_q[0:2], y};
            result_valid_d = 1'b1;
            ch_d           = 2'd0;
            j_d            = 2'd0;
            if (!mode) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            ch_d = ch_q + 2'd1;
            j_d  = ch_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        j_d     = 2'd0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        j_d     = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      i_q            <= 4'b0000;
      dwell_q        <= 4'd0;
      cnt_q          <= 4'd0;
      ch_q           <= 2'd0;
      cap_q          <= 4'b0000;
      j_q            <= 2'd0;
      busy_q         <= 1'b0;
      result_q       <= 4'b0000;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      i_q            <= i_d;
      dwell_q        <= dwell_d;
      cnt_q          <= cnt_d;
      ch_q           <= ch_d;
      cap_q          <= cap_d;
      j_q            <= j_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
    end
  end

  assign i            = i_q;
  assign j0           = j_q[1];
  assign j1           = j_q[0];
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// Directed bench for mux41_scan_ctrl with a combinational 4:1 mux closing the y loop.
module tb_mux41_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] dwell;
  logic [0:3] data_in;
  logic       y;
  logic [0:3] i_w;
  logic       j0;
  logic       j1;
  logic       busy;
  logic [0:3] result;
  logic       result_valid;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  mux41_scan_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .mode         (mode),
    .dwell        (dwell),
    .data_in      (data_in),
    .y            (y),
    .i            (i_w),
    .j0           (j0),
    .j1           (j1),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .done         (done)
  );

  // The mux under control: index 0 selects i[0].
  assign y = i_w[{j0, j1}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},   {7'd0, busy},         8'd0);
    chk({tag, " sel"},    {6'd0, j0, j1},       8'd0);
    chk({tag, " i"},      {4'd0, i_w},          8'd0);
    chk({tag, " result"}, {4'd0, result},       8'd0);
    chk({tag, " rv"},     {7'd0, result_valid}, 8'd0);
    chk({tag, " done"},   {7'd0, done},         8'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b1;
    stop    = 1'b0;
    mode    = 1'b0;
    dwell   = 4'd0;
    data_in = 4'b1111;

    // Reset with start held high: must stay idle and zero.
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    chk("start+stop idle busy", {7'd0, busy}, 8'd0);
    chk("start+stop idle i", {4'd0, i_w}, 8'd0);
    start = 1'b0;
    stop  = 1'b0;
    tick();

    // Single sweep, dwell 0.
    data_in = 4'b1010;
    dwell   = 4'd0;
    mode    = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("single load busy", {7'd0, busy}, 8'd1);
    chk("single load i", {4'd0, i_w}, 8'b1010);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("single sel", {6'd0, j0, j1}, 8'(k));
      chk("single busy", {7'd0, busy}, 8'd1);
      chk("single rv early", {7'd0, result_valid}, 8'd0);
    end
    tick();
    chk("single result", {4'd0, result}, 8'b1010);
    chk("single rv", {7'd0, result_valid}, 8'd1);
    chk("single done", {7'd0, done}, 8'd1);
    chk("single busy done", {7'd0, busy}, 8'd0);
    tick();
    chk("single done clr", {7'd0, done}, 8'd0);
    chk("single rv clr", {7'd0, result_valid}, 8'd0);
    chk("single result hold", {4'd0, result}, 8'b1010);

    // Dwell 3: 4 cycles per channel, done on the 18th cycle.
    data_in = 4'b0001;
    dwell   = 4'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      chk("dwell done", {7'd0, done}, (n == 17) ? 8'd1 : 8'd0);
      if (n <= 16) chk("dwell sel", {6'd0, j0, j1}, 8'((n - 1) / 4));
    end
    chk("dwell result", {4'd0, result}, 8'b0001);
    chk("dwell rv", {7'd0, result_valid}, 8'd1);
    tick();

    // Continuous sweeps; mode cleared during the second sweep.
    data_in = 4'b0110;
    dwell   = 4'd1;
    mode    = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      chk("cont rv", {7'd0, result_valid}, (n == 9 || n == 17) ? 8'd1 : 8'd0);
      chk("cont done", {7'd0, done}, (n == 17) ? 8'd1 : 8'd0);
      chk("cont busy", {7'd0, busy}, (n == 17) ? 8'd0 : 8'd1);
      if (n == 9 || n == 17) chk("cont result", {4'd0, result}, 8'b0110);
      if (n == 12) mode = 1'b0;
    end
    tick();
    chk("cont idle busy", {7'd0, busy}, 8'd0);

    // Abort during ch=2; start while busy is ignored.
    data_in = 4'b1111;
    dwell   = 4'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    data_in = 4'b0000;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort sel ch2", {6'd0, j0, j1}, 8'd2);
    chk("abort i kept", {4'd0, i_w}, 8'b1111);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort busy", {7'd0, busy}, 8'd0);
    chk("abort sel", {6'd0, j0, j1}, 8'd0);
    chk("abort result", {4'd0, result}, 8'b0110);
    chk("abort rv", {7'd0, result_valid}, 8'd0);
    chk("abort done", {7'd0, done}, 8'd0);
    tick();
    tick();
    chk("abort done later", {7'd0, done}, 8'd0);
    chk("abort rv later", {7'd0, result_valid}, 8'd0);

    // Async reset mid-scan at ch=1.
    data_in = 4'b1010;
    dwell   = 4'd2;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 4; n++) tick();
    chk("arst pre sel", {6'd0, j0, j1}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    tick();
    rst_n = 1'b1;
    chk("arst held rv", {7'd0, result_valid}, 8'd0);

    // Restart after reset.
    data_in = 4'b0101;
    dwell   = 4'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("restart done", {7'd0, done}, (n == 5) ? 8'd1 : 8'd0);
    end
    chk("restart result", {4'd0, result}, 8'b0101);
    chk("restart rv", {7'd0, result_valid}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
